// File: rtl/ib_c2v_skew_pipe.sv
// Skew/align delay pipe for check-to-variable messages feeding a chain of decomposed LUT stages.
// Channel k is tapped after k*STAGE_LAT registers and the same chain continues to the decision-node tap.
module ib_c2v_skew_pipe #(
    parameter int QUAN_SIZE = 3,
    parameter int DV        = 3,
    parameter int STAGE_LAT = 2,
    localparam int TOTAL_LAT = DV * STAGE_LAT,
    localparam int OCC_W     = $clog2(TOTAL_LAT + 1)
) (
    input  logic                    read_clk,
    input  logic                    rstn,
    input  logic                    en,
    input  logic                    flush,
    input  logic                    in_valid,
    input  logic [DV*QUAN_SIZE-1:0] c2v_in,
    input  logic [QUAN_SIZE-1:0]    ch_llr_in,
    output logic [DV*QUAN_SIZE-1:0] e_skew,
    output logic [DV*QUAN_SIZE-1:0] e_dn,
    output logic [QUAN_SIZE-1:0]    ch_llr_dn,
    output logic                    dn_valid,
    output logic [OCC_W-1:0]        occupancy
);
    logic [QUAN_SIZE-1:0] r_c2v [DV][TOTAL_LAT];
    logic [QUAN_SIZE-1:0] r_llr [TOTAL_LAT];
    logic [TOTAL_LAT-1:0] r_vld;
    logic [OCC_W-1:0]     r_occ;
    logic                 w_shift;

    // Data holds during a flush so the skew taps keep their last contents.
    assign w_shift = en & ~flush;

    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < DV; k++) begin
                for (int i = 0; i < TOTAL_LAT; i++) begin
                    r_c2v[k][i] <= '0;
                end
            end
            for (int i = 0; i < TOTAL_LAT; i++) begin
                r_llr[i] <= '0;
            end
        end else if (w_shift) begin
            for (int k = 0; k < DV; k++) begin
                r_c2v[k][0] <= c2v_in[k*QUAN_SIZE +: QUAN_SIZE];
                for (int i = 1; i < TOTAL_LAT; i++) begin
                    r_c2v[k][i] <= r_c2v[k][i-1];
                end
            end
            r_llr[0] <= ch_llr_in;
            for (int i = 1; i < TOTAL_LAT; i++) begin
                r_llr[i] <= r_llr[i-1];
            end
        end
    end

    // Occupancy tracks the valid chain exactly, so it is bounded by TOTAL_LAT by construction.
    always_ff @(posedge read_clk or negedge rstn) begin
        if (!rstn) begin
            r_vld <= '0;
            r_occ <= '0;
        end else if (flush) begin
            r_vld <= '0;
            r_occ <= '0;
        end else if (en) begin
            r_vld <= {r_vld[TOTAL_LAT-2:0], in_valid};
            r_occ <= r_occ + OCC_W'(in_valid) - OCC_W'(r_vld[TOTAL_LAT-1]);
        end
    end

    for (genvar k = 0; k < DV; k++) begin : g_ch
        if (k == 0) begin : g_pass
            assign e_skew[0 +: QUAN_SIZE] = c2v_in[0 +: QUAN_SIZE];
        end else begin : g_tap
            assign e_skew[k*QUAN_SIZE +: QUAN_SIZE] = r_c2v[k][k*STAGE_LAT-1];
        end
        assign e_dn[k*QUAN_SIZE +: QUAN_SIZE] = r_c2v[k][TOTAL_LAT-1];
    end

    assign ch_llr_dn = r_llr[TOTAL_LAT-1];
    assign dn_valid  = r_vld[TOTAL_LAT-1];
    assign occupancy = r_occ;
endmodule
